// File: rtl/lif_pkg.sv
// ---------------------------------------------------------------------------
// lif_pkg
// Shared definitions for the leaky integrate-and-fire neuron array:
//   - lif_state_e : sequencing states of the timestep controller
//   - RST_ZERO / RST_SUB : post-spike membrane reset modes
//   - sat_add() : unsigned add that clamps at the all-ones value of a width
// ---------------------------------------------------------------------------
package lif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } lif_state_e;

  localparam logic RST_ZERO = 1'b0;
  localparam logic RST_SUB  = 1'b1;

  // Adds two unsigned values of width w (w <= 32) with one extra bit of
  // headroom and clamps the result to 2^w-1 instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int          w);
    logic [32:0] sum;
    logic [32:0] maxv;
    sum  = {1'b0, a} + {1'b0, b};
    maxv = (33'd1 << w) - 33'd1;
    if (sum > maxv) begin
      return maxv[31:0];
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/lif_neuron_core.sv
// ---------------------------------------------------------------------------
// lif_neuron_core
// Purely combinational update of one neuron for one timestep. The array
// instantiates a single copy and steers each neuron through it in turn.
// Ports:
//   i_u         current membrane potential
//   i_refrac    remaining refractory timesteps
//   i_current   injected current for this timestep
//   i_threshold firing threshold
//   i_mode      RST_ZERO: membrane cleared on spike, RST_SUB: threshold removed
//   o_u         next membrane potential
//   o_refrac    next refractory count
//   o_spike     neuron fires this timestep
// ---------------------------------------------------------------------------
module lif_neuron_core
  import lif_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int BETA_SHIFT   = 1,
  parameter int REFRAC_STEPS = 2,
  parameter int REF_W        = 2
) (
  input  logic [WIDTH-1:0] i_u,
  input  logic [REF_W-1:0] i_refrac,
  input  logic [WIDTH-1:0] i_current,
  input  logic [WIDTH-1:0] i_threshold,
  input  logic             i_mode,
  output logic [WIDTH-1:0] o_u,
  output logic [REF_W-1:0] o_refrac,
  output logic             o_spike
);

  logic [WIDTH-1:0] w_decay;
  logic [WIDTH-1:0] w_sum;

  // Leak is a plain right shift; a refractory neuron only leaks and counts
  // down, otherwise it integrates with clamping and compares to threshold.
  // Subtract mode cannot underflow because it is only taken when sum >= theta.
  always_comb begin
    w_decay  = i_u >> BETA_SHIFT;
    w_sum    = WIDTH'(sat_add(32'(w_decay), 32'(i_current), WIDTH));
    o_u      = w_sum;
    o_refrac = '0;
    o_spike  = 1'b0;
    if (i_refrac != '0) begin
      o_u      = w_decay;
      o_refrac = i_refrac - 1'b1;
    end else if (w_sum >= i_threshold) begin
      o_spike  = 1'b1;
      o_u      = (i_mode == RST_SUB) ? (w_sum - i_threshold) : '0;
      o_refrac = REF_W'(REFRAC_STEPS);
    end
  end

endmodule

// File: rtl/lif_array.sv
// ---------------------------------------------------------------------------
// lif_array
// Array of NUM_NEURONS leaky integrate-and-fire neurons sharing one update
// datapath. A timestep is accepted on i_in_valid/o_in_ready, the neurons are
// updated one per clock, and the spike vector plus membrane states are
// published together and held until i_out_ready.
// Optional build macro: LIF_SPIKE_COUNT_EN adds o_spike_count, a saturating
// per-neuron spike counter of CNT_W bits.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_in_valid       timestep input valid
//   o_in_ready       block idle and able to accept a timestep
//   i_current        per-neuron current, neuron i at [i*WIDTH +: WIDTH]
//   i_threshold      firing threshold
//   i_reset_mode     0 = reset to zero, 1 = subtract threshold
//   o_out_valid      result valid
//   i_out_ready      consumer takes the result
//   o_spikes         spike vector of the completed timestep
//   o_state          membrane states after the completed timestep
//   o_spike_count    (LIF_SPIKE_COUNT_EN only) per-neuron spike totals
// ---------------------------------------------------------------------------
module lif_array
  import lif_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int NUM_NEURONS  = 4,
  parameter int BETA_SHIFT   = 1,
  parameter int REFRAC_STEPS = 2,
  parameter int CNT_W        = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [NUM_NEURONS*WIDTH-1:0] i_current,
  input  logic [WIDTH-1:0]             i_threshold,
  input  logic                         i_reset_mode,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [NUM_NEURONS-1:0]       o_spikes,
  output logic [NUM_NEURONS*WIDTH-1:0] o_state
`ifdef LIF_SPIKE_COUNT_EN
  ,
  output logic [NUM_NEURONS*CNT_W-1:0] o_spike_count
`endif
);

  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int REF_W = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

  lif_state_e r_fsm;
  lif_state_e w_fsmNext;

  logic [IDX_W-1:0]             r_index;
  logic [WIDTH-1:0]             r_membrane [NUM_NEURONS];
  logic [REF_W-1:0]             r_refrac   [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]       r_spikeWork;
  logic [NUM_NEURONS*WIDTH-1:0] r_curCap;
  logic [WIDTH-1:0]             r_thetaCap;
  logic                         r_modeCap;

  logic             w_accept;
  logic             w_lastIdx;
  logic [WIDTH-1:0] w_uCur;
  logic [WIDTH-1:0] w_iCur;
  logic [WIDTH-1:0] w_uNext;
  logic [REF_W-1:0] w_refracNext;
  logic             w_spike;

  assign w_accept  = i_in_valid && o_in_ready;
  assign w_lastIdx = (r_index == IDX_W'(NUM_NEURONS - 1));
  assign w_uCur    = r_membrane[r_index];
  assign w_iCur    = r_curCap[r_index*WIDTH +: WIDTH];

  lif_neuron_core #(
    .WIDTH       (WIDTH),
    .BETA_SHIFT  (BETA_SHIFT),
    .REFRAC_STEPS(REFRAC_STEPS),
    .REF_W       (REF_W)
  ) u_core (
    .i_u        (w_uCur),
    .i_refrac   (r_refrac[r_index]),
    .i_current  (w_iCur),
    .i_threshold(r_thetaCap),
    .i_mode     (r_modeCap),
    .o_u        (w_uNext),
    .o_refrac   (w_refracNext),
    .o_spike    (w_spike)
  );

  // State register of the timestep controller.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fsm <= ST_IDLE;
    end else begin
      r_fsm <= w_fsmNext;
    end
  end

  // Next-state logic: accept, walk every neuron once, then hold the result
  // until the consumer takes it.
  always_comb begin
    w_fsmNext = r_fsm;
    case (r_fsm)
      ST_IDLE:   if (i_in_valid)  w_fsmNext = ST_UPDATE;
      ST_UPDATE: if (w_lastIdx)   w_fsmNext = ST_DONE;
      ST_DONE:   if (i_out_ready) w_fsmNext = ST_IDLE;
      default:                    w_fsmNext = ST_IDLE;
    endcase
  end

  // Handshake outputs are pure decodes of the state.
  always_comb begin
    o_in_ready  = (r_fsm == ST_IDLE);
    o_out_valid = (r_fsm == ST_DONE);
  end

  // Datapath. Inputs are captured at accept so later input changes cannot
  // disturb the step. The last neuron's fresh result is merged straight into
  // the published outputs on the edge that enters DONE, so intermediate
  // states are never visible.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_index     <= '0;
      r_spikeWork <= '0;
      r_curCap    <= '0;
      r_thetaCap  <= '0;
      r_modeCap   <= RST_ZERO;
      o_spikes    <= '0;
      o_state     <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_membrane[i] <= '0;
        r_refrac[i]   <= '0;
      end
    end else if (w_accept) begin
      r_curCap   <= i_current;
      r_thetaCap <= i_threshold;
      r_modeCap  <= i_reset_mode;
      r_index    <= '0;
    end else if (r_fsm == ST_UPDATE) begin
      r_membrane[r_index]  <= w_uNext;
      r_refrac[r_index]    <= w_refracNext;
      r_spikeWork[r_index] <= w_spike;
      r_index              <= r_index + 1'b1;
      if (w_lastIdx) begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
          if (IDX_W'(i) == r_index) begin
            o_state[i*WIDTH +: WIDTH] <= w_uNext;
            o_spikes[i]               <= w_spike;
          end else begin
            o_state[i*WIDTH +: WIDTH] <= r_membrane[i];
            o_spikes[i]               <= r_spikeWork[i];
          end
        end
      end
    end
  end

`ifdef LIF_SPIKE_COUNT_EN
  logic [CNT_W-1:0] r_spikeCnt [NUM_NEURONS];
  logic [CNT_W-1:0] w_cntInc;

  assign w_cntInc = CNT_W'(sat_add(32'(r_spikeCnt[r_index]), 32'd1, CNT_W));

  // Per-neuron spike totals, bumped as each neuron is processed and published
  // alongside the spike vector.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_spike_count <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_spikeCnt[i] <= '0;
      end
    end else if ((r_fsm == ST_UPDATE) && !w_accept) begin
      if (w_spike) begin
        r_spikeCnt[r_index] <= w_cntInc;
      end
      if (w_lastIdx) begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
          if ((IDX_W'(i) == r_index) && w_spike) begin
            o_spike_count[i*CNT_W +: CNT_W] <= w_cntInc;
          end else begin
            o_spike_count[i*CNT_W +: CNT_W] <= r_spikeCnt[i];
          end
        end
      end
    end
  end
`else
  logic w_unused_cntw;
  assign w_unused_cntw = |CNT_W;
`endif

endmodule

// File: tb/tb_lif_array.sv
// ---------------------------------------------------------------------------
// tb_lif_array
// Self-checking bench for lif_array (WIDTH=8, NUM_NEURONS=4, BETA_SHIFT=1,
// REFRAC_STEPS=2, CNT_W=2). Define LIF_SPIKE_COUNT_EN to also exercise the
// spike counters.
// ---------------------------------------------------------------------------
module tb_lif_array;

  localparam int W  = 8;
  localparam int NN = 4;
  localparam int CW = 2;

  logic              clk;
  logic              rst;
  logic              inValid;
  logic              inReady;
  logic [NN*W-1:0]   current;
  logic [W-1:0]      threshold;
  logic              resetMode;
  logic              outValid;
  logic              outReady;
  logic [NN-1:0]     spikes;
  logic [NN*W-1:0]   state;
`ifdef LIF_SPIKE_COUNT_EN
  logic [NN*CW-1:0]  spikeCount;
`endif

  int total = 0;
  int bad   = 0;

  // reference model: per-neuron membrane, refractory budget, spike totals
  int          mU   [NN];
  int          mRef [NN];
  int          mCnt [NN];
  logic [NN-1:0] mSpk;
  logic [NN*W-1:0] mState;

  lif_array #(
    .WIDTH(W), .NUM_NEURONS(NN), .BETA_SHIFT(1), .REFRAC_STEPS(2), .CNT_W(CW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (inValid),
    .o_in_ready  (inReady),
    .i_current   (current),
    .i_threshold (threshold),
    .i_reset_mode(resetMode),
    .o_out_valid (outValid),
    .i_out_ready (outReady),
    .o_spikes    (spikes),
    .o_state     (state)
`ifdef LIF_SPIKE_COUNT_EN
    ,
    .o_spike_count(spikeCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // compare one value and keep the tallies
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // reference: one timestep computed straight from the neuron rules
  task automatic modelStep(input logic [NN*W-1:0] cur, input logic [W-1:0] th, input logic mode);
    int d, s;
    for (int i = 0; i < NN; i++) begin
      d = mU[i] / 2;
      mSpk[i] = 1'b0;
      if (mRef[i] > 0) begin
        mU[i] = d;
        mRef[i] = mRef[i] - 1;
      end else begin
        s = d + int'(cur[i*W +: W]);
        if (s > 255) s = 255;
        if (s >= int'(th)) begin
          mSpk[i] = 1'b1;
          mU[i] = mode ? s - int'(th) : 0;
          mRef[i] = 2;
          mCnt[i] = (mCnt[i] < 3) ? mCnt[i] + 1 : 3;
        end else begin
          mU[i] = s;
        end
      end
      mState[i*W +: W] = W'(mU[i]);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NN; i++) begin
      mU[i] = 0; mRef[i] = 0; mCnt[i] = 0;
    end
    mSpk = '0;
    mState = '0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  // Offer one timestep, then scramble the inputs to prove they were captured,
  // and wait (bounded) for the result. lat counts edges from accept edge to
  // the first edge after which out_valid is high.
  task automatic applyStimulus(input logic [NN*W-1:0] cur, input logic [W-1:0] th,
                               input logic mode, output int lat);
    int guard;
    lat = 0;
    @(negedge clk);
    inValid = 1'b1; current = cur; threshold = th; resetMode = mode;
    guard = 0;
    while (!inReady && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!inReady) checkOutput("accept_timeout", 64'(inReady), 64'd1);
    @(posedge clk);
    lat = 1;
    #1;
    inValid = 1'b0;
    current = {$urandom, $urandom};
    threshold = W'($urandom);
    resetMode = ~mode;
    while (!outValid && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
    end
    if (!outValid) checkOutput("done_timeout", 64'(outValid), 64'd1);
    modelStep(cur, th, mode);
  endtask

  typedef struct {
    bit              rstBefore;
    logic [NN*W-1:0] cur;
    logic [W-1:0]    th;
    logic            mode;
    logic [NN-1:0]   expSpk;
    logic [NN*W-1:0] expState;
  } vec_t;

  vec_t vecs [13];
  int lat;

  initial begin
    rst = 1'b1; inValid = 1'b0; current = '0; threshold = '0;
    resetMode = 1'b0; outReady = 1'b1;
    modelReset();

    vecs[0]  = '{1'b0, 32'h0000_0064, 8'd127, 1'b0, 4'b0000, 32'h0000_0064};
    vecs[1]  = '{1'b0, 32'h0000_0064, 8'd127, 1'b0, 4'b0001, 32'h0000_0000};
    vecs[2]  = '{1'b0, 32'h0000_0064, 8'd127, 1'b0, 4'b0000, 32'h0000_0000};
    vecs[3]  = '{1'b0, 32'h0000_0064, 8'd127, 1'b0, 4'b0000, 32'h0000_0000};
    vecs[4]  = '{1'b0, 32'h0000_0064, 8'd127, 1'b0, 4'b0000, 32'h0000_0064};
    vecs[5]  = '{1'b1, 32'h0000_6400, 8'd127, 1'b1, 4'b0000, 32'h0000_6400};
    vecs[6]  = '{1'b0, 32'h0000_6400, 8'd127, 1'b1, 4'b0010, 32'h0000_1700};
    vecs[7]  = '{1'b0, 32'h0000_6400, 8'd127, 1'b1, 4'b0000, 32'h0000_0B00};
    vecs[8]  = '{1'b0, 32'h0000_6400, 8'd127, 1'b1, 4'b0000, 32'h0000_0500};
    vecs[9]  = '{1'b0, 32'h0000_6400, 8'd127, 1'b1, 4'b0000, 32'h0000_6600};
    vecs[10] = '{1'b1, 32'h00C8_0000, 8'd255, 1'b0, 4'b0000, 32'h00C8_0000};
    vecs[11] = '{1'b0, 32'h00FF_0000, 8'd127, 1'b0, 4'b0100, 32'h0000_0000};
    vecs[12] = '{1'b1, 32'h0000_0000, 8'd0,   1'b0, 4'b1111, 32'h0000_0000};

    // reset state
    #2;
    checkOutput("rst_in_ready", 64'(inReady), 64'd1);
    checkOutput("rst_out_valid", 64'(outValid), 64'd0);
    checkOutput("rst_spikes", 64'(spikes), 64'd0);
    checkOutput("rst_state", 64'(state), 64'd0);
    doReset();

    // directed table
    for (int v = 0; v < 13; v++) begin
      if (vecs[v].rstBefore) doReset();
      applyStimulus(vecs[v].cur, vecs[v].th, vecs[v].mode, lat);
      checkOutput($sformatf("vec%0d_spikes", v), 64'(spikes), 64'(vecs[v].expSpk));
      checkOutput($sformatf("vec%0d_state", v), 64'(state), 64'(vecs[v].expState));
      checkOutput($sformatf("vec%0d_latency", v), 64'(lat), 64'd5);
    end

    // backpressure: result must be held while the consumer stalls
    doReset();
    outReady = 1'b0;
    applyStimulus(32'h1020_C864, 8'd100, 1'b1, lat);
    checkOutput("bp_latency", 64'(lat), 64'd5);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkOutput("bp_out_valid", 64'(outValid), 64'd1);
      checkOutput("bp_in_ready", 64'(inReady), 64'd0);
      checkOutput("bp_spikes", 64'(spikes), 64'(mSpk));
      checkOutput("bp_state", 64'(state), 64'(mState));
    end
    @(negedge clk);
    outReady = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release_in_ready", 64'(inReady), 64'd1);
    checkOutput("bp_release_out_valid", 64'(outValid), 64'd0);

    // reset in the middle of an update aborts the step completely
    doReset();
    applyStimulus(32'h6464_6464, 8'd127, 1'b0, lat);
    checkOutput("pre_abort_state", 64'(state), 64'h6464_6464);
    @(negedge clk);
    inValid = 1'b1; current = 32'h6464_6464; threshold = 8'd127; resetMode = 1'b0;
    @(posedge clk);
    #1 inValid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("abort_out_valid", 64'(outValid), 64'd0);
    checkOutput("abort_in_ready", 64'(inReady), 64'd1);
    checkOutput("abort_state", 64'(state), 64'd0);
    checkOutput("abort_spikes", 64'(spikes), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      checkOutput("abort_no_result", 64'(outValid), 64'd0);
    end
    applyStimulus(32'h6464_6464, 8'd127, 1'b0, lat);
    checkOutput("post_abort_spikes", 64'(spikes), 64'd0);
    checkOutput("post_abort_state", 64'(state), 64'h6464_6464);

    // random timesteps against the reference model
    doReset();
    for (int n = 0; n < 40; n++) begin
      logic [NN*W-1:0] rc;
      logic [W-1:0] rt;
      rc = {$urandom};
      rt = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom_range(40, 255));
      applyStimulus(rc, rt, 1'($urandom_range(0, 1)), lat);
      checkOutput($sformatf("rnd%0d_spikes", n), 64'(spikes), 64'(mSpk));
      checkOutput($sformatf("rnd%0d_state", n), 64'(state), 64'(mState));
    end

`ifdef LIF_SPIKE_COUNT_EN
    // counter saturation and clear
    doReset();
    for (int n = 0; n < 13; n++) begin
      applyStimulus(32'h0000_0000, 8'd0, 1'b0, lat);
      checkOutput($sformatf("cnt%0d_n0", n), 64'(spikeCount[1:0]), 64'(mCnt[0]));
    end
    checkOutput("cnt_saturated", 64'(spikeCount[1:0]), 64'd3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("cnt_cleared", 64'(spikeCount), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
